seq_lock: RTL and testbench

SEQ_LOCK -- requirements
Module: seq_lock

---
 rtl/seq_lock.sv | 239 +++++++++++++++++++++++
 tb/tb_seq_lock.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_lock.sv
// seq_lock: digit-sequence combination lock with a programmable code.
//
// The user keys CODE_LEN hex digits, each accepted by a one-cycle 'enter'
// strobe. A full entry that matches the code register unlocks the block
// (OPEN) for OPEN_CYCLES clocks. While open, an enter with set_mode held
// high starts programming (PROG) of a new code. All outputs are registered.
//
// Optional feature macro: SEQ_LOCK_LOCKOUT_EN
//   defined   -> MAX_TRIES consecutive wrong codes put the block in LOCKOUT
//                for LOCKOUT_CYCLES clocks with 'alarm' high.
//   undefined -> no lockout state or fail counter; 'alarm' is tied low.
//
// Ports:
//   clk        in   1  single rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   digit      in   4  digit value, any of 16 values
//   enter      in   1  one-cycle strobe accepting 'digit'
//   clear      in   1  one-cycle strobe aborting a partial entry
//   set_mode   in   1  level, requests code programming
//   y          out  1  unlocked indication
//   a          out  1  locked indication, always ~y
//   alarm      out  1  lockout active
//   entry_cnt  out  3  digits accepted in the current entry
//   last_digit out  4  most recently accepted digit
module seq_lock #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_TRIES      = 3,
    parameter logic [15:0] OPEN_CYCLES    = 16'd1000,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    input  logic       set_mode,
    output logic       y,
    output logic       a,
    output logic       alarm,
    output logic [2:0] entry_cnt,
    output logic [3:0] last_digit
);

    // Reject out-of-range parameters at elaboration time.
    if (CODE_LEN < 1 || CODE_LEN > 4) begin : g_badCodeLen
        $error("seq_lock: CODE_LEN must be 1..4");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_badMaxTries
        $error("seq_lock: MAX_TRIES must be 1..7");
    end
    if (OPEN_CYCLES == 16'd0 || LOCKOUT_CYCLES == 16'd0) begin : g_badCycles
        $error("seq_lock: OPEN_CYCLES and LOCKOUT_CYCLES must be nonzero");
    end

    // Only the low CODE_LEN digits of the code take part in compare/program.
    localparam logic [15:0] CODE_MASK = 16'((32'd1 << (4 * CODE_LEN)) - 32'd1);
    localparam logic [2:0]  LAST_IDX  = 3'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROG    = 2'd2
`ifdef SEQ_LOCK_LOCKOUT_EN
        ,
        LOCKOUT = 2'd3
`endif
    } StateType;

    StateType    r_state;
    logic [15:0] r_entryBuf;
    logic [15:0] r_code;
    logic [15:0] r_timer;
    logic [2:0]  r_entryCnt;
    logic [3:0]  r_lastDigit;
    logic        r_y;
    logic        r_a;

    StateType    w_nextState;
    logic [15:0] w_nextBuf;
    logic [15:0] w_nextCode;
    logic [15:0] w_nextTimer;
    logic [2:0]  w_nextCnt;
    logic [3:0]  w_nextLast;
    logic [15:0] w_shiftBuf;
    logic [15:0] w_timerLimit;
    logic        w_timerDone;
    logic        w_codeDone;
    logic        w_match;
    logic        w_nextUnlocked;

`ifdef SEQ_LOCK_LOCKOUT_EN
    logic [2:0]  r_failCnt;
    logic [2:0]  w_nextFail;
    logic        r_alarm;
    assign alarm = r_alarm;
`else
    assign alarm = 1'b0;
`endif

    assign y          = r_y;
    assign a          = r_a;
    assign entry_cnt  = r_entryCnt;
    assign last_digit = r_lastDigit;

    // The newest digit always lands in the low nibble, so after CODE_LEN
    // enters the first-keyed digit sits in the most significant used nibble.
    assign w_shiftBuf = {r_entryBuf[11:0], digit};
    assign w_codeDone = (r_entryCnt == LAST_IDX);
    assign w_match    = ((w_shiftBuf ^ r_code) & CODE_MASK) == 16'd0;

    // One timer serves both OPEN and LOCKOUT; it restarts from zero on entry
    // and the state ends when it has reached its limit.
    assign w_timerLimit = (r_state == OPEN) ? (OPEN_CYCLES - 16'd1)
                                            : (LOCKOUT_CYCLES - 16'd1);
    assign w_timerDone  = (r_timer == w_timerLimit);

    // Next-state and next-register computation. Every value defaults to
    // holding (timer defaults to zero) and each state overrides what it owns.
    always_comb begin
        w_nextState = r_state;
        w_nextBuf   = r_entryBuf;
        w_nextCode  = r_code;
        w_nextTimer = 16'd0;
        w_nextCnt   = r_entryCnt;
        w_nextLast  = r_lastDigit;
`ifdef SEQ_LOCK_LOCKOUT_EN
        w_nextFail  = r_failCnt;
`endif
        case (r_state)
            ENTRY: begin
                // clear has priority over a simultaneous enter
                if (clear) begin
                    w_nextCnt = 3'd0;
                end else if (enter) begin
                    w_nextBuf  = w_shiftBuf;
                    w_nextLast = digit;
                    if (w_codeDone) begin
                        w_nextCnt = 3'd0;
                        if (w_match) begin
                            w_nextState = OPEN;
`ifdef SEQ_LOCK_LOCKOUT_EN
                            w_nextFail  = 3'd0;
`endif
                        end else begin
`ifdef SEQ_LOCK_LOCKOUT_EN
                            w_nextFail = r_failCnt + 3'd1;
                            if (w_nextFail == 3'(MAX_TRIES)) begin
                                w_nextState = LOCKOUT;
                            end
`endif
                        end
                    end else begin
                        w_nextCnt = r_entryCnt + 3'd1;
                    end
                end
            end
            OPEN: begin
                // A user enter takes precedence over the hold timer expiring.
                if (enter) begin
                    w_nextState = set_mode ? PROG : ENTRY;
                    w_nextCnt   = 3'd0;
                end else if (w_timerDone) begin
                    w_nextState = ENTRY;
                end else begin
                    w_nextTimer = r_timer + 16'd1;
                end
            end
            PROG: begin
                // Dropping set_mode abandons programming and keeps the old code.
                if (!set_mode) begin
                    w_nextState = ENTRY;
                    w_nextCnt   = 3'd0;
                end else if (clear) begin
                    w_nextCnt = 3'd0;
                end else if (enter) begin
                    w_nextBuf  = w_shiftBuf;
                    w_nextLast = digit;
                    if (w_codeDone) begin
                        w_nextCode  = (r_code & ~CODE_MASK) | (w_shiftBuf & CODE_MASK);
                        w_nextState = ENTRY;
                        w_nextCnt   = 3'd0;
                    end else begin
                        w_nextCnt = r_entryCnt + 3'd1;
                    end
                end
            end
`ifdef SEQ_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (w_timerDone) begin
                    w_nextState = ENTRY;
                    w_nextFail  = 3'd0;
                end else begin
                    w_nextTimer = r_timer + 16'd1;
                end
            end
`endif
            default: begin
                w_nextState = ENTRY;
                w_nextCnt   = 3'd0;
            end
        endcase
    end

    assign w_nextUnlocked = (w_nextState == OPEN) || (w_nextState == PROG);

    // State and all output registers. y/a/alarm are derived from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ENTRY;
            r_entryBuf  <= 16'd0;
            r_code      <= DEFAULT_CODE;
            r_timer     <= 16'd0;
            r_entryCnt  <= 3'd0;
            r_lastDigit <= 4'd0;
            r_y         <= 1'b0;
            r_a         <= 1'b1;
`ifdef SEQ_LOCK_LOCKOUT_EN
            r_failCnt   <= 3'd0;
            r_alarm     <= 1'b0;
`endif
        end else begin
            r_state     <= w_nextState;
            r_entryBuf  <= w_nextBuf;
            r_code      <= w_nextCode;
            r_timer     <= w_nextTimer;
            r_entryCnt  <= w_nextCnt;
            r_lastDigit <= w_nextLast;
            r_y         <= w_nextUnlocked;
            r_a         <= !w_nextUnlocked;
`ifdef SEQ_LOCK_LOCKOUT_EN
            r_failCnt   <= w_nextFail;
            r_alarm     <= (w_nextState == LOCKOUT);
`endif
        end
    end

endmodule

// File: tb/tb_seq_lock.sv
// tb_seq_lock: self-checking bench for seq_lock.
// A reference model (digit queue, countdown timers, mode number) predicts
// every output each cycle; fixed vectors and hand-written sequences add
// literal expectations for the key scenarios. Works with or without
// SEQ_LOCK_LOCKOUT_EN defined.
module tb_seq_lock;

    localparam int CODE_LEN       = 4;
    localparam int MAX_TRIES      = 3;
    localparam int OPEN_CYCLES    = 1000;
    localparam int LOCKOUT_CYCLES = 5000;
    localparam logic [15:0] DEFAULT_CODE = 16'h1234;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_PROG  = 2;
    localparam int M_LOCK  = 3;

    logic       clk;
    logic       rst;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic       set_mode;
    logic       y;
    logic       a;
    logic       alarm;
    logic [2:0] entry_cnt;
    logic [3:0] last_digit;

    int checkCount;
    int errorCount;

    // reference model state
    int          mMode;
    logic [3:0]  mDigits[$];
    logic [15:0] mCode;
    logic [15:0] codeMask;
    logic [3:0]  mLast;
    int          mFails;
    int          mOpenLeft;
    int          mLockLeft;

    typedef struct {
        logic [3:0] d;
        logic       en;
        logic       cl;
        logic       sm;
        logic       expY;
        logic [2:0] expCnt;
        logic [3:0] expLast;
    } VectorType;

    VectorType vectors[12];

    seq_lock #(
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .MAX_TRIES      (MAX_TRIES),
        .OPEN_CYCLES    (16'(OPEN_CYCLES)),
        .LOCKOUT_CYCLES (16'(LOCKOUT_CYCLES))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit      (digit),
        .enter      (enter),
        .clear      (clear),
        .set_mode   (set_mode),
        .y          (y),
        .a          (a),
        .alarm      (alarm),
        .entry_cnt  (entry_cnt),
        .last_digit (last_digit)
    );

    // free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] joinDigits();
        logic [15:0] v;
        v = 16'd0;
        foreach (mDigits[i]) v = (v << 4) | 16'(mDigits[i]);
        return v;
    endfunction

    task automatic modelReset();
        mMode = M_ENTRY;
        mDigits.delete();
        mCode = DEFAULT_CODE;
        mLast = 4'd0;
        mFails = 0;
        mOpenLeft = 0;
        mLockLeft = 0;
    endtask

    // advance the model by one clock edge with the given inputs
    task automatic modelStep(input logic [3:0] d, input logic en, input logic cl, input logic sm);
        logic [15:0] v;
        case (mMode)
            M_ENTRY: begin
                if (cl) begin
                    mDigits.delete();
                end else if (en) begin
                    mDigits.push_back(d);
                    mLast = d;
                    if (mDigits.size() == CODE_LEN) begin
                        v = joinDigits();
                        mDigits.delete();
                        if (v == (mCode & codeMask)) begin
                            mMode = M_OPEN;
                            mOpenLeft = OPEN_CYCLES;
                            mFails = 0;
                        end else begin
                            mFails++;
`ifdef SEQ_LOCK_LOCKOUT_EN
                            if (mFails >= MAX_TRIES) begin
                                mMode = M_LOCK;
                                mLockLeft = LOCKOUT_CYCLES;
                            end
`endif
                        end
                    end
                end
            end
            M_OPEN: begin
                if (en) begin
                    mDigits.delete();
                    mMode = sm ? M_PROG : M_ENTRY;
                end else begin
                    mOpenLeft--;
                    if (mOpenLeft == 0) mMode = M_ENTRY;
                end
            end
            M_PROG: begin
                if (!sm) begin
                    mDigits.delete();
                    mMode = M_ENTRY;
                end else if (cl) begin
                    mDigits.delete();
                end else if (en) begin
                    mDigits.push_back(d);
                    mLast = d;
                    if (mDigits.size() == CODE_LEN) begin
                        mCode = (mCode & ~codeMask) | (joinDigits() & codeMask);
                        mDigits.delete();
                        mMode = M_ENTRY;
                    end
                end
            end
            default: begin
                mLockLeft--;
                if (mLockLeft == 0) begin
                    mMode = M_ENTRY;
                    mFails = 0;
                end
            end
        endcase
    endtask

    task automatic checkValue(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // compare every output against the model prediction
    task automatic checkOutput(input string name);
        logic [9:0] expVec;
        logic [9:0] gotVec;
        logic       expY;
        expY   = (mMode == M_OPEN) || (mMode == M_PROG);
        expVec = {expY, !expY, (mMode == M_LOCK), 3'(mDigits.size()), mLast};
        gotVec = {y, a, alarm, entry_cnt, last_digit};
        checkValue(name, 16'(gotVec), 16'(expVec));
    endtask

    // drive one cycle of inputs from a negedge, step the model at the
    // posedge, and return at the following negedge
    task automatic applyStimulus(input logic [3:0] d, input logic en, input logic cl, input logic sm);
        digit    = d;
        enter    = en;
        clear    = cl;
        set_mode = sm;
        @(posedge clk);
        modelStep(d, en, cl, sm);
        @(negedge clk);
    endtask

    task automatic stepCheck(input logic [3:0] d, input logic en, input logic cl, input logic sm, input string name);
        applyStimulus(d, en, cl, sm);
        checkOutput(name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepCheck(4'd0, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic enterCode(input logic [15:0] c, input logic sm);
        for (int i = 0; i < CODE_LEN; i++)
            stepCheck(4'(c >> (4 * (CODE_LEN - 1 - i))), 1'b1, 1'b0, sm, "code");
    endtask

    // asynchronous reset asserted between edges and checked before any edge
    task automatic doReset();
        rst      = 1'b1;
        digit    = 4'd0;
        enter    = 1'b0;
        clear    = 1'b0;
        set_mode = 1'b0;
        #2;
        modelReset();
        checkOutput("reset_model");
        checkValue("reset_out", 16'({y, a, alarm, entry_cnt, last_digit}), 16'b0_1_0_000_0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] d;
        logic       en;
        logic       cl;
        logic       sm;

        checkCount = 0;
        errorCount = 0;
        codeMask   = 16'd0;
        for (int i = 0; i < CODE_LEN; i++) codeMask = codeMask | (16'hF << (4 * i));
        rst      = 1'b0;
        digit    = 4'd0;
        enter    = 1'b0;
        clear    = 1'b0;
        set_mode = 1'b0;
        modelReset();

        // wrong code, clear beating enter, then the right code
        vectors[0]  = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1};
        vectors[1]  = '{4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd2};
        vectors[2]  = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd3};
        vectors[3]  = '{4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5};
        vectors[4]  = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1};
        vectors[5]  = '{4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd2};
        vectors[6]  = '{4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd2};
        vectors[7]  = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1};
        vectors[8]  = '{4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd2};
        vectors[9]  = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd3};
        vectors[10] = '{4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd4};
        vectors[11] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd4};

        @(negedge clk);
        doReset();

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            stepCheck(vectors[i].d, vectors[i].en, vectors[i].cl, vectors[i].sm, "vector_model");
            checkValue($sformatf("row%0d", i), 16'({y, entry_cnt, last_digit}),
                       16'({vectors[i].expY, vectors[i].expCnt, vectors[i].expLast}));
        end

        // open hold time: unlocked on the edge of the 4th enter, 1000 cycles
        idle(OPEN_CYCLES - 2);
        checkValue("open_hold", 16'(y), 16'd1);
        idle(1);
        checkValue("open_expire", 16'(y), 16'd0);

        $display("[TB] programming a new code");
        enterCode(16'h1234, 1'b0);
        checkValue("prog_open", 16'(y), 16'd1);
        stepCheck(4'd7, 1'b1, 1'b0, 1'b1, "to_prog");
        checkValue("prog_y", 16'({y, entry_cnt}), 16'({1'b1, 3'd0}));
        enterCode(16'h9876, 1'b1);
        checkValue("prog_done", 16'({y, entry_cnt}), 16'({1'b0, 3'd0}));
        enterCode(16'h1234, 1'b0);
        checkValue("old_code_rejected", 16'(y), 16'd0);
        enterCode(16'h9876, 1'b0);
        checkValue("new_code_opens", 16'(y), 16'd1);
        stepCheck(4'd0, 1'b1, 1'b0, 1'b0, "relock");
        checkValue("relock", 16'(y), 16'd0);
        doReset();
        enterCode(16'h1234, 1'b0);
        checkValue("default_after_reset", 16'(y), 16'd1);
        stepCheck(4'd0, 1'b1, 1'b0, 1'b0, "relock");

        $display("[TB] abandoned programming");
        enterCode(16'h1234, 1'b0);
        stepCheck(4'd0, 1'b1, 1'b0, 1'b1, "to_prog");
        stepCheck(4'd5, 1'b1, 1'b0, 1'b1, "prog_d1");
        stepCheck(4'd6, 1'b1, 1'b0, 1'b1, "prog_d2");
        checkValue("prog_partial", 16'({y, entry_cnt}), 16'({1'b1, 3'd2}));
        stepCheck(4'd0, 1'b0, 1'b0, 1'b0, "set_mode_drop");
        checkValue("prog_abort", 16'({y, entry_cnt}), 16'({1'b0, 3'd0}));
        enterCode(16'h1234, 1'b0);
        checkValue("old_code_kept", 16'(y), 16'd1);
        stepCheck(4'd0, 1'b1, 1'b0, 1'b0, "relock");

        $display("[TB] repeated wrong codes");
        for (int i = 0; i < MAX_TRIES; i++) enterCode(16'h0000, 1'b0);
`ifdef SEQ_LOCK_LOCKOUT_EN
        checkValue("lockout_alarm", 16'(alarm), 16'd1);
        enterCode(16'h1234, 1'b0);
        checkValue("lockout_ignores", 16'({y, alarm, entry_cnt}), 16'({1'b0, 1'b1, 3'd0}));
        idle(LOCKOUT_CYCLES - CODE_LEN - 1);
        checkValue("lockout_hold", 16'(alarm), 16'd1);
        idle(1);
        checkValue("lockout_end", 16'(alarm), 16'd0);
`else
        checkValue("no_alarm", 16'(alarm), 16'd0);
`endif
        enterCode(16'h1234, 1'b0);
        checkValue("open_after_fails", 16'(y), 16'd1);
        stepCheck(4'd0, 1'b1, 1'b0, 1'b0, "relock");

        $display("[TB] randomized run");
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end else begin
                en = 1'($urandom_range(0, 1));
                cl = ($urandom_range(0, 15) == 0);
                sm = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 3) != 0 && mDigits.size() < CODE_LEN)
                    d = 4'(mCode >> (4 * (CODE_LEN - 1 - mDigits.size())));
                else
                    d = 4'($urandom_range(0, 15));
                stepCheck(d, en, cl, sm, "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
